// File: rtl/bcp_implication_collector.sv
// bcp_implication_collector
// Buffers the implications (variable, value) produced during one BCP
// propagation round. When the round ends it scans every variable. For each
// variable it presents the matching slots to conflict_analyzer, using a
// CLEAR / EVAL / SAMPLE sequence. It reports the lowest-index conflicting
// variable to the BCP controller.
//
// Optional feature: define BCP_EARLY_EXIT_EN to end the scan at the first
// conflicting variable instead of always scanning all VAR_CNT variables.
module bcp_implication_collector #(
    parameter int SLOT_NUM = 4,
    parameter int VAR_CNT  = 4,
    parameter int VW       = (VAR_CNT > 1) ? $clog2(VAR_CNT) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    // implication stream from clause evaluation
    input  logic                              imp_valid,
    output logic                              imp_ready,
    input  logic [VW-1:0]                     imp_var,
    input  logic                              imp_val,
    // round control
    input  logic                              round_end,
    // conflict_analyzer side
    output logic [SLOT_NUM-1:0]               an_mask,
    output logic [SLOT_NUM-1:0]               an_assignment,
    output logic                              an_en,
    input  logic                              an_conflict,
    // result to the BCP controller
    output logic                              done,
    output logic                              conflict_found,
    output logic [VW-1:0]                     conflict_var,
    output logic [$clog2(SLOT_NUM+1)-1:0]     imp_count
);

    localparam int CW = $clog2(SLOT_NUM + 1);

`ifdef BCP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    // Scan sequencer states
    localparam logic [2:0] ST_COLLECT = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_EVAL    = 3'd2;
    localparam logic [2:0] ST_SAMPLE  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [VW-1:0]       v_q, v_d;
    logic [CW-1:0]       count_q, count_d;

    // Implication buffer. Slot s is valid while slot_used_q[s] is set.
    logic [VW-1:0]       slot_var_q [SLOT_NUM];
    logic [VW-1:0]       slot_var_d [SLOT_NUM];
    logic [SLOT_NUM-1:0] slot_val_q, slot_val_d;
    logic [SLOT_NUM-1:0] slot_used_q, slot_used_d;

    logic                cf_q, cf_d;
    logic [VW-1:0]       cv_q, cv_d;

    logic                accept;
    logic                last_var;
    logic                scan_active;

    // Handshake and scan status decoded from the registered state
    always_comb begin
        imp_ready   = (state_q == ST_COLLECT) && (count_q < CW'(SLOT_NUM));
        accept      = imp_valid && imp_ready;
        last_var    = (v_q == VW'(VAR_CNT - 1));
        scan_active = (state_q == ST_EVAL) || (state_q == ST_SAMPLE);
    end

    // Next-state and scan-index logic of the round sequencer
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path through the case/if leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        case (state_q)
            ST_COLLECT: begin
                if (round_end) begin
                    state_d = ST_CLEAR;
                    v_d     = '0;
                end
            end
            ST_CLEAR:  state_d = ST_EVAL;
            ST_EVAL:   state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                if (EARLY_EXIT && an_conflict) begin
                    state_d = ST_DONE;
                end else if (last_var) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CLEAR;
                    v_d     = v_q + VW'(1);
                end
            end
            ST_DONE:   state_d = ST_COLLECT;
            default:   state_d = ST_COLLECT;
        endcase
    end

    // Buffer fill in arrival order; whole buffer emptied when the round closes
    always_comb begin
        slot_var_d  = slot_var_q;
        slot_val_d  = slot_val_q;
        slot_used_d = slot_used_q;
        count_d     = count_q;
        if (state_q == ST_DONE) begin
            for (int s = 0; s < SLOT_NUM; s++) begin
                slot_var_d[s] = '0;
            end
            slot_val_d  = '0;
            slot_used_d = '0;
            count_d     = '0;
        end else if (accept) begin
            for (int s = 0; s < SLOT_NUM; s++) begin
                if (count_q == CW'(s)) begin
                    slot_var_d[s]  = imp_var;
                    slot_val_d[s]  = imp_val;
                    slot_used_d[s] = 1'b1;
                end
            end
            count_d = count_q + CW'(1);
        end
    end

    // First conflict of the round wins; results clear when a new scan starts
    always_comb begin
        cf_d = cf_q;
        cv_d = cv_q;
        if ((state_q == ST_COLLECT) && round_end) begin
            cf_d = 1'b0;
            cv_d = '0;
        end else if ((state_q == ST_SAMPLE) && an_conflict && !cf_q) begin
            cf_d = 1'b1;
            cv_d = v_q;
        end
    end

    // State, buffer and result registers with synchronous reset
    // NOTE: the small slot buffer is reset along with the control state. This
    // keeps the unused slots at a known value, because an_assignment exposes
    // every slot's value bit whether or not the slot is in use.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            v_q         <= '0;
            count_q     <= '0;
            for (int s = 0; s < SLOT_NUM; s++) begin
                slot_var_q[s] <= '0;
            end
            slot_val_q  <= '0;
            slot_used_q <= '0;
            cf_q        <= 1'b0;
            cv_q        <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register here samples the pre-edge value of its inputs.
            state_q     <= state_d;
            v_q         <= v_d;
            count_q     <= count_d;
            slot_var_q  <= slot_var_d;
            slot_val_q  <= slot_val_d;
            slot_used_q <= slot_used_d;
            cf_q        <= cf_d;
            cv_q        <= cv_d;
        end
    end

    // Analyzer drive: slot match for the current variable during EVAL/SAMPLE
    always_comb begin
        an_mask       = '0;
        an_assignment = '0;
        if (scan_active) begin
            for (int s = 0; s < SLOT_NUM; s++) begin
                an_mask[s] = slot_used_q[s] && (slot_var_q[s] == v_q);
            end
            an_assignment = slot_val_q;
        end
    end

    // Remaining outputs come straight from registers or state decode
    always_comb begin
        an_en          = scan_active;
        done           = (state_q == ST_DONE);
        conflict_found = cf_q;
        conflict_var   = cv_q;
        imp_count      = count_q;
    end

endmodule

// File: tb/tb_bcp_implication_collector.sv
// Self-checking bench for bcp_implication_collector (SLOT_NUM = VAR_CNT = 4).
// It carries a behavioural conflict_analyzer. That analyzer latches a conflict
// while en is high and clears while en is low. Expected results come from a
// queue-based model of the round.
module tb_bcp_implication_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       imp_valid;
    logic       imp_ready;
    logic [1:0] imp_var;
    logic       imp_val;
    logic       round_end;
    logic [3:0] an_mask;
    logic [3:0] an_assignment;
    logic       an_en;
    logic       an_conflict;
    logic       done;
    logic       conflict_found;
    logic [1:0] conflict_var;
    logic [2:0] imp_count;

    int checks   = 0;
    int failures = 0;

    bcp_implication_collector #(.SLOT_NUM(4), .VAR_CNT(4)) dut (
        .clk(clk), .rst(rst),
        .imp_valid(imp_valid), .imp_ready(imp_ready),
        .imp_var(imp_var), .imp_val(imp_val),
        .round_end(round_end),
        .an_mask(an_mask), .an_assignment(an_assignment),
        .an_en(an_en), .an_conflict(an_conflict),
        .done(done), .conflict_found(conflict_found),
        .conflict_var(conflict_var), .imp_count(imp_count)
    );

    always #5 clk = ~clk;

    // Behavioural conflict_analyzer: the selected slots hold both values
    always @(posedge clk) begin
        if (!an_en) an_conflict <= 1'b0;
        else        an_conflict <= (|(an_mask & an_assignment)) && (|(an_mask & ~an_assignment));
    end

    // Reference model: implications of the current round in arrival order
    typedef struct packed {
        logic [1:0] v;
        logic       b;
    } imp_t;
    imp_t model_q[$];

    function automatic logic [3:0] model_mask(input int k);
        logic [3:0] m;
        m = '0;
        foreach (model_q[i]) if (int'(model_q[i].v) == k) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [3:0] model_assign();
        logic [3:0] m;
        m = '0;
        foreach (model_q[i]) m[i] = model_q[i].b;
        return m;
    endfunction

    function automatic bit model_conflict(input int k);
        bit has0, has1;
        has0 = 0;
        has1 = 0;
        foreach (model_q[i]) begin
            if (int'(model_q[i].v) == k) begin
                if (model_q[i].b) has1 = 1;
                else              has0 = 1;
            end
        end
        return has0 && has1;
    endfunction

    function automatic int exp_latency(input bit found, input int var_idx);
`ifdef BCP_EARLY_EXIT_EN
        return found ? 3 * (var_idx + 1) + 1 : 13;
`else
        return 13;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one implication and wait (bounded) for it to be taken
    task automatic push(input logic [1:0] vv, input logic bb);
        int   guard;
        imp_t e;
        guard     = 0;
        imp_valid = 1'b1;
        imp_var   = vv;
        imp_val   = bb;
        while (imp_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("push_ready_wait", guard < 50, 1);
        @(negedge clk);
        imp_valid = 1'b0;
        e.v = vv;
        e.b = bb;
        model_q.push_back(e);
        check("imp_count_fill", imp_count, model_q.size());
    endtask

    task automatic start_round();
        round_end = 1'b1;
        @(negedge clk);
        round_end = 1'b0;
    endtask

    // Called at the first negedge after the round_end sample edge (cycle 1)
    task automatic scan_check(input string tag, input bit exp_found, input logic [1:0] exp_var,
                              input bit poke);
        int exp_lat;
        int cyc;
        int k;
        bit seen;
        exp_lat = exp_latency(exp_found, int'(exp_var));
        seen    = 0;
        cyc     = 1;
        while (cyc <= 40 && !seen) begin
            if (poke) round_end = (cyc == 4);
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                k = (cyc - 1) / 3;
                if (cyc < exp_lat) begin
                    check({tag, "_an_en"}, an_en, (cyc % 3) != 1);
                    check({tag, "_ready_scan"}, imp_ready, 0);
                    if ((cyc % 3) != 1) begin
                        check({tag, "_mask"}, an_mask, model_mask(k));
                        check({tag, "_assign"}, an_assignment, model_assign());
                    end else begin
                        check({tag, "_mask_clear"}, an_mask, 0);
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        round_end = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_found"}, conflict_found, exp_found);
        check({tag, "_var"}, conflict_var, exp_found ? exp_var : 2'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_count_clr"}, imp_count, 0);
        check({tag, "_ready_back"}, imp_ready, 1);
        check({tag, "_found_hold"}, conflict_found, exp_found);
        check({tag, "_var_hold"}, conflict_var, exp_found ? exp_var : 2'd0);
        model_q.delete();
    endtask

    typedef struct {
        string      name;
        int         n;
        logic [7:0] vars;
        logic [3:0] vals;
        logic       exp_found;
        logic [1:0] exp_var;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   efound;
        logic [1:0] evar;
        imp_t e;
        int   seen_done;

        tbl[0] = '{"two_no_conf",  2, 8'h02, 4'b0001, 1'b0, 2'd0};
        tbl[1] = '{"var1_conf",    3, 8'h1D, 4'b0001, 1'b1, 2'd1};
        tbl[2] = '{"var1_and_3",   4, 8'hDD, 4'b1001, 1'b1, 2'd1};
        tbl[3] = '{"empty",        0, 8'h00, 4'b0000, 1'b0, 2'd0};
        tbl[4] = '{"var3_conf",    4, 8'h0F, 4'b1110, 1'b1, 2'd3};
        tbl[5] = '{"dup_same",     2, 8'h0A, 4'b0011, 1'b0, 2'd0};
        tbl[6] = '{"var0_conf",    2, 8'h00, 4'b0001, 1'b1, 2'd0};

        rst = 1'b1; imp_valid = 1'b0; imp_var = '0; imp_val = 1'b0; round_end = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values
        check("rst_ready",  imp_ready, 1);
        check("rst_mask",   an_mask, 0);
        check("rst_assign", an_assignment, 0);
        check("rst_en",     an_en, 0);
        check("rst_done",   done, 0);
        check("rst_found",  conflict_found, 0);
        check("rst_var",    conflict_var, 0);
        check("rst_count",  imp_count, 0);

        // Table-driven rounds
        for (int t = 0; t < 7; t++) begin
            for (int s = 0; s < tbl[t].n; s++) push(tbl[t].vars[2*s +: 2], tbl[t].vals[s]);
            check({tbl[t].name, "_ready_full"}, imp_ready, tbl[t].n < 4);
            start_round();
            scan_check(tbl[t].name, tbl[t].exp_found, tbl[t].exp_var, 1'b0);
        end

        // Fourth accept coincides with round_end; fifth stalls through the scan
        push(2'd0, 1'b1);
        push(2'd1, 1'b0);
        push(2'd1, 1'b1);
        imp_valid = 1'b1; imp_var = 2'd2; imp_val = 1'b1; round_end = 1'b1;
        check("t5_ready_4th", imp_ready, 1);
        @(negedge clk);
        round_end = 1'b0;
        e.v = 2'd2; e.b = 1'b1;
        model_q.push_back(e);
        imp_var = 2'd3; imp_val = 1'b0;
        check("t5_fifth_stall", imp_ready, 0);
        check("t5_count4", imp_count, 4);
        scan_check("t5", 1'b1, 2'd1, 1'b0);
        @(negedge clk);
        imp_valid = 1'b0;
        e.v = 2'd3; e.b = 1'b0;
        model_q.push_back(e);
        check("t5_fifth_taken", imp_count, 1);
        start_round();
        scan_check("t5b", 1'b0, 2'd0, 1'b0);

        // Reset during the var 2 EVAL cycle
        push(2'd2, 1'b1);
        push(2'd2, 1'b0);
        push(2'd0, 1'b1);
        start_round();
        repeat (7) @(negedge clk);
        check("t6_eval_en", an_en, 1);
        check("t6_eval_mask", an_mask, 4'b0011);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        check("t6_en", an_en, 0);
        check("t6_count", imp_count, 0);
        check("t6_done", done, 0);
        check("t6_ready", imp_ready, 1);
        check("t6_mask", an_mask, 0);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) seen_done++;
            @(negedge clk);
        end
        check("t6_no_done", seen_done, 0);
        push(2'd3, 1'b1);
        push(2'd3, 1'b0);
        start_round();
        scan_check("t6_after", 1'b1, 2'd3, 1'b0);

        // Randomized rounds against the model
        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) push(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            efound = 0;
            evar   = '0;
            for (int k = 3; k >= 0; k--) begin
                if (model_conflict(k)) begin
                    efound = 1;
                    evar   = 2'(k);
                end
            end
            start_round();
            scan_check("rand", efound, evar, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
